game_sequencer: RTL and testbench

Top-level game-flow controller between `vga_controller`, the start menu, and the gameplay blocks (car, objects, stars, color mapper). It sequences MENU → COUNTDOWN → PLAY ↔ PAUSE → CRASH → OVER and back to MENU. It derives a per-frame tick from vertical sync and gates gameplay motion with it. It also keeps a BCD survival score and issues the single-cycle `replay` pulse that restarts a round.

---
 rtl/game_pkg.sv | 45 ++++
 rtl/bcd_counter4.sv | 20 ++
 rtl/game_sequencer.sv | 147 ++++++++++++++
 tb/tb_game_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encoding, 4-digit BCD type, HID keycodes
// and the saturating BCD increment.
package game_pkg;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    CRASH     = 3'd4,
    OVER      = 3'd5
  } game_state_t;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd4_t;

  localparam logic [7:0] KEYCODE_P     = 8'h13;
  localparam logic [7:0] KEYCODE_ENTER = 8'h28;

  // +1 with decimal carry per digit; 9999 stays 9999
  function automatic bcd4_t bcd4_inc(input bcd4_t v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (r != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return bcd4_t'(r);
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear and saturating increment.
module bcd_counter4
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  inc,
  output bcd4_t value
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      value <= '0;
    end else if (inc) begin
      value <= bcd4_inc(value);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: MENU -> COUNTDOWN -> PLAY <-> PAUSE -> CRASH -> OVER.
// Define GAME_SEQ_HISCORE_EN to build the best-score register.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned COUNT_SECS     = 3,
  parameter int unsigned CRASH_FRAMES   = 120,
  parameter logic [7:0]  KEY_PAUSE      = KEYCODE_P,
  parameter logic [7:0]  KEY_ENTER      = KEYCODE_ENTER
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vs,
  input  logic        start_req,
  input  logic        crash,
  input  logic [7:0]  keycode,
  output game_state_t state,
  output logic        run,
  output logic        frame_en,
  output logic [1:0]  count_digit,
  output bcd4_t       score,
  output bcd4_t       hiscore,
  output logic        replay
);

  localparam int unsigned FW = $clog2(FRAMES_PER_SEC > 1 ? FRAMES_PER_SEC : 2);
  localparam int unsigned CW = $clog2(CRASH_FRAMES > 1 ? CRASH_FRAMES : 2);
  localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CRASH_FRAMES - 1);

  logic          vs_q;
  logic [7:0]    prev_key;
  logic [FW-1:0] fcnt;
  logic [CW-1:0] ccnt;

  logic tick_c, second_c, pause_ev_c, enter_ev_c, score_clr_c, score_inc_c;

  // tick marks the rising edge of vs (end of the active-low sync pulse)
  assign tick_c      = vs & ~vs_q;
  assign second_c    = tick_c && (fcnt == F_LAST);
  assign pause_ev_c  = (keycode == KEY_PAUSE) && (prev_key != KEY_PAUSE);
  assign enter_ev_c  = (keycode == KEY_ENTER) && (prev_key != KEY_ENTER);
  assign score_clr_c = (state == MENU) || ((state == OVER) && enter_ev_c);
  assign score_inc_c = (state == PLAY) && second_c && !crash;

  bcd_counter4 u_score (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (score_clr_c),
    .inc   (score_inc_c),
    .value (score)
  );

  // run is written together with every transition so it tracks state exactly
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= MENU;
      run         <= 1'b0;
      frame_en    <= 1'b0;
      count_digit <= 2'd0;
      replay      <= 1'b0;
      vs_q        <= 1'b1;
      prev_key    <= 8'h00;
      fcnt        <= '0;
      ccnt        <= '0;
    end else begin
      vs_q     <= vs;
      prev_key <= keycode;
      frame_en <= tick_c && (state == PLAY);
      replay   <= 1'b0;
      run      <= 1'b0;
      case (state)
        MENU: begin
          fcnt        <= '0;
          count_digit <= 2'd0;
          if (start_req) begin
            state       <= COUNTDOWN;
            count_digit <= 2'(COUNT_SECS);
          end
        end
        COUNTDOWN: begin
          if (second_c) begin
            fcnt <= '0;
            if (count_digit == 2'd1) begin
              state       <= PLAY;
              run         <= 1'b1;
              count_digit <= 2'd0;
            end else begin
              count_digit <= count_digit - 2'd1;
            end
          end else if (tick_c) begin
            fcnt <= fcnt + FW'(1);
          end
        end
        PLAY: begin
          if (tick_c) fcnt <= second_c ? '0 : fcnt + FW'(1);
          if (crash) begin
            state <= CRASH;
            ccnt  <= '0;
          end else if (pause_ev_c) begin
            state <= PAUSE;
          end else begin
            run <= 1'b1;
          end
        end
        PAUSE: begin
          if (pause_ev_c) begin
            state <= PLAY;
            run   <= 1'b1;
          end
        end
        CRASH: begin
          if (tick_c) begin
            if (ccnt == C_LAST) begin
              state <= OVER;
              ccnt  <= '0;
            end else begin
              ccnt <= ccnt + CW'(1);
            end
          end
        end
        OVER: begin
          if (enter_ev_c) begin
            state  <= MENU;
            replay <= 1'b1;
          end
        end
        default: state <= MENU;
      endcase
    end
  end

`ifdef GAME_SEQ_HISCORE_EN
  // BCD digits compare correctly as a plain binary vector
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hiscore <= '0;
    end else if ((state == OVER) && enter_ev_c && (score > hiscore)) begin
      hiscore <= score;
    end
  end
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed scoreboard bench for game_sequencer: default-parameter instance for
// the game flow, a fast-second instance for score saturation.
module tb_game_sequencer;
  import game_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, vs, start_req, crash, start2, crash2;
  logic [7:0]  keycode, key2;
  logic [2:0]  st, st2;
  logic        run, fe, rp, run2, fe2, rp2;
  logic [1:0]  cd, cd2;
  logic [15:0] sc, hs, sc2, hs2;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

`ifdef GAME_SEQ_HISCORE_EN
  localparam logic [15:0] HS_EXP = 16'h0003;
`else
  localparam logic [15:0] HS_EXP = 16'h0000;
`endif

  game_sequencer dut (
    .Clk(clk), .Reset_n(rst_n), .vs(vs), .start_req(start_req), .crash(crash),
    .keycode(keycode), .state(st), .run(run), .frame_en(fe), .count_digit(cd),
    .score(sc), .hiscore(hs), .replay(rp)
  );

  game_sequencer #(.FRAMES_PER_SEC(1), .COUNT_SECS(1), .CRASH_FRAMES(2)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .vs(vs), .start_req(start2), .crash(crash2),
    .keycode(key2), .state(st2), .run(run2), .frame_en(fe2), .count_digit(cd2),
    .score(sc2), .hiscore(hs2), .replay(rp2)
  );

  task automatic push_exp(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one vs pulse: low for a cycle, tick at the following edge
  task automatic tick();
    vs = 1'b0;
    step();
    vs = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b1; start_req = 1'b0; crash = 1'b0; keycode = 8'h00;
    start2 = 1'b0; crash2 = 1'b0; key2 = 8'h00;
    step(); step();
    push_exp("rst_state", 32'(MENU)); chk(32'(st));
    push_exp("rst_run", 0);           chk(32'(run));
    push_exp("rst_frame_en", 0);      chk(32'(fe));
    push_exp("rst_digit", 0);         chk(32'(cd));
    push_exp("rst_score", 0);         chk(32'(sc));
    push_exp("rst_replay", 0);        chk(32'(rp));
    rst_n = 1'b1;

    // countdown
    start_req = 1'b1;
    push_exp("cd_state", 32'(COUNTDOWN));
    push_exp("cd_digit_start", 3);
    step(); start_req = 1'b0;
    chk(32'(st)); chk(32'(cd));
    for (int i = 1; i <= 180; i++) begin
      tick();
      if (i == 59)  begin push_exp("cd_digit_59", 3);  chk(32'(cd)); end
      if (i == 60)  begin push_exp("cd_digit_60", 2);  chk(32'(cd)); end
      if (i == 120) begin push_exp("cd_digit_120", 1); chk(32'(cd)); end
      if (i == 179) begin push_exp("cd_state_179", 32'(COUNTDOWN)); chk(32'(st)); end
      if (i == 180) begin
        push_exp("play_state", 32'(PLAY)); chk(32'(st));
        push_exp("play_run", 1);           chk(32'(run));
        push_exp("play_no_fe_entry", 0);   chk(32'(fe));
        push_exp("play_digit", 0);         chk(32'(cd));
      end
    end

    // play 125 ticks
    for (int i = 1; i <= 125; i++) begin
      tick();
      if (i == 1) begin
        push_exp("fe_first", 1); chk(32'(fe));
        step();
        push_exp("fe_one_cycle", 0); chk(32'(fe));
      end
      if (i == 119) begin push_exp("score_119", 16'h0001); chk(32'(sc)); end
      if (i == 120) begin push_exp("score_120", 16'h0002); chk(32'(sc)); end
    end
    push_exp("score_125", 16'h0002); chk(32'(sc));

    // pause held for 50 ticks, then release and press again
    keycode = KEYCODE_P;
    push_exp("pause_state", 32'(PAUSE)); push_exp("pause_run", 0);
    step(); chk(32'(st)); chk(32'(run));
    for (int i = 0; i < 50; i++) tick();
    push_exp("pause_held_state", 32'(PAUSE)); chk(32'(st));
    push_exp("pause_score", 16'h0002);        chk(32'(sc));
    push_exp("pause_no_fe", 0);               chk(32'(fe));
    keycode = 8'h00; step();
    keycode = KEYCODE_P;
    push_exp("resume_state", 32'(PLAY)); push_exp("resume_run", 1);
    step(); chk(32'(st)); chk(32'(run));
    keycode = 8'h00;
    for (int i = 0; i < 54; i++) tick();
    push_exp("resume_54", 16'h0002); chk(32'(sc));
    tick();
    push_exp("resume_55", 16'h0003); chk(32'(sc));

    // crash beats pause
    crash = 1'b1; keycode = KEYCODE_P;
    push_exp("crash_state", 32'(CRASH)); push_exp("crash_run", 0);
    step(); chk(32'(st)); chk(32'(run));
    crash = 1'b0; keycode = 8'h00;
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (i == 119) begin push_exp("crash_119", 32'(CRASH)); chk(32'(st)); end
      if (i == 120) begin
        push_exp("over_state", 32'(OVER)); chk(32'(st));
        push_exp("over_score", 16'h0003);  chk(32'(sc));
      end
    end

    // enter acknowledges game over
    keycode = KEYCODE_ENTER;
    push_exp("replay_pulse", 1); push_exp("replay_state", 32'(MENU));
    push_exp("replay_score", 0); push_exp("replay_hiscore", 32'(HS_EXP));
    step(); chk(32'(rp)); chk(32'(st)); chk(32'(sc)); chk(32'(hs));
    push_exp("replay_one_cycle", 0);
    step(); chk(32'(rp));
    keycode = 8'h00;

    // second round, reset mid-PLAY
    start_req = 1'b1; step(); start_req = 1'b0;
    for (int i = 0; i < 180; i++) tick();
    push_exp("round2_play", 32'(PLAY)); chk(32'(st));
    for (int i = 0; i < 65; i++) tick();
    push_exp("round2_score", 16'h0001); chk(32'(sc));
    rst_n = 1'b0; step(); step();
    push_exp("midrst_state", 32'(MENU)); chk(32'(st));
    push_exp("midrst_score", 0);         chk(32'(sc));
    push_exp("midrst_run", 0);           chk(32'(run));
    push_exp("midrst_replay", 0);        chk(32'(rp));
    push_exp("midrst_hiscore", 0);       chk(32'(hs));
    rst_n = 1'b1;

    // saturation on the one-tick-per-second instance
    start2 = 1'b1; step(); start2 = 1'b0;
    push_exp("sat_countdown", 32'(COUNTDOWN)); chk(32'(st2));
    tick();
    push_exp("sat_play", 32'(PLAY)); chk(32'(st2));
    for (int i = 0; i < 9998; i++) tick();
    push_exp("sat_9998", 16'h9998); chk(32'(sc2));
    tick();
    push_exp("sat_9999", 16'h9999); chk(32'(sc2));
    for (int i = 0; i < 120; i++) tick();
    push_exp("sat_hold", 16'h9999);   chk(32'(sc2));
    push_exp("sat_state", 32'(PLAY)); chk(32'(st2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
